// File: rtl/key_entry_buffer.sv
// Keypad entry front end: debounces scanner key codes into single press events and
// assembles decimal digits into a BCD entry buffer that is committed on ENTER.
module key_entry_buffer #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned NDIG      = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [4:0]                   key_in,
    output logic                         key_evt,
    output logic [3:0]                   key_code,
    output logic [4*NDIG-1:0]            digits,
    output logic [$clog2(NDIG+1)-1:0]    digit_cnt,
    output logic                         full,
    output logic [4*NDIG-1:0]            value,
    output logic                         value_valid
);

    localparam int unsigned CNTW = $clog2(DB_CYCLES + 1);
    localparam int unsigned DCW  = $clog2(NDIG + 1);
    localparam int unsigned BW   = 4 * NDIG;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StDebounce = 2'd1;
    localparam logic [1:0] StHeld     = 2'd2;
    localparam logic [1:0] StRelease  = 2'd3;

    localparam logic [CNTW-1:0] CntOne  = CNTW'(1);
    localparam logic [CNTW-1:0] CntLast = CNTW'(DB_CYCLES - 1);
    localparam logic [DCW-1:0]  DigMax  = DCW'(NDIG);

    localparam logic [3:0] KeyBksp  = 4'hA;
    localparam logic [3:0] KeyClear = 4'hB;
    localparam logic [3:0] KeyEnter = 4'hF;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic            evt_q, evt_d;
    logic [3:0]      code_q, code_d;
    logic [BW-1:0]   digits_q, digits_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [BW-1:0]   value_q, value_d;
    logic            vv_q, vv_d;

    logic key_present;
    logic key_match;

    assign key_present = ~key_in[4];
    assign key_match   = key_present && (key_in[3:0] == cand_q);

    // Debounce FSM. The event is raised on the same edge the counter would reach
    // DB_CYCLES, so the counter never actually holds that value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        evt_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (key_present) begin
                    cand_d  = key_in[3:0];
                    cnt_d   = CntOne;
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                if (key_match) begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        evt_d   = 1'b1;
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StHeld: begin
                if (!key_present) begin
                    cnt_d   = CntOne;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (key_present) begin
                    // Release bounce: back to HELD without a new event.
                    cnt_d   = '0;
                    state_d = StHeld;
                end else if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Entry buffer update, applied on the edge that raises key_evt.
    always_comb begin
        code_d   = code_q;
        digits_d = digits_q;
        dcnt_d   = dcnt_q;
        value_d  = value_q;
        vv_d     = 1'b0;
        if (evt_d) begin
            code_d = cand_q;
            if (cand_q <= 4'd9) begin
                if (dcnt_q < DigMax) begin
                    digits_d = (digits_q << 4) | BW'(cand_q);
                    dcnt_d   = dcnt_q + DCW'(1);
                end
            end else if (cand_q == KeyBksp) begin
                if (dcnt_q != '0) begin
                    digits_d = digits_q >> 4;
                    dcnt_d   = dcnt_q - DCW'(1);
                end
            end else if (cand_q == KeyClear) begin
                digits_d = '0;
                dcnt_d   = '0;
            end else if (cand_q == KeyEnter) begin
                if (dcnt_q != '0) begin
                    value_d  = digits_q;
                    vv_d     = 1'b1;
                    digits_d = '0;
                    dcnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            cand_q   <= '0;
            evt_q    <= 1'b0;
            code_q   <= '0;
            digits_q <= '0;
            dcnt_q   <= '0;
            value_q  <= '0;
            vv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            evt_q    <= evt_d;
            code_q   <= code_d;
            digits_q <= digits_d;
            dcnt_q   <= dcnt_d;
            value_q  <= value_d;
            vv_q     <= vv_d;
        end
    end

    assign key_evt     = evt_q;
    assign key_code    = code_q;
    assign digits      = digits_q;
    assign digit_cnt   = dcnt_q;
    assign full        = (dcnt_q == DigMax);
    assign value       = value_q;
    assign value_valid = vv_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed bench for key_entry_buffer: debounce timing, bounce rejection and buffer editing.
module tb_key_entry_buffer;

    logic        CLK;
    logic        RST_N;
    logic [4:0]  key_in;
    logic        key_evt;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic        full;
    logic [15:0] value;
    logic        value_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int evt_cnt  = 0;
    int vv_cnt   = 0;
    int first_evt;
    int evt0;
    int vv0;

    key_entry_buffer #(
        .DB_CYCLES(16),
        .NDIG     (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .key_in     (key_in),
        .key_evt    (key_evt),
        .key_code   (key_code),
        .digits     (digits),
        .digit_cnt  (digit_cnt),
        .full       (full),
        .value      (value),
        .value_valid(value_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance n cycles sampling at negedge; first_evt = 1-based cycle of first key_evt, -1 if none.
    task automatic run(input int n);
        first_evt = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (key_evt === 1'b1) begin
                evt_cnt++;
                if (first_evt < 0) first_evt = i;
            end
            if (value_valid === 1'b1) vv_cnt++;
        end
    endtask

    task automatic press(input logic [4:0] k);
        key_in = k;
        run(20);
        key_in = 5'h10;
        run(20);
    endtask

    initial begin
        RST_N  = 1'b0;
        key_in = 5'h10;
        run(3);
        check("rst_key_evt", key_evt, 0);
        check("rst_key_code", key_code, 0);
        check("rst_digits", digits, 0);
        check("rst_digit_cnt", digit_cnt, 0);
        check("rst_full", full, 0);
        check("rst_value", value, 0);
        check("rst_value_valid", value_valid, 0);
        RST_N = 1'b1;
        run(3);

        // 1: clean press of 5
        evt0   = evt_cnt;
        key_in = 5'h05;
        run(100);
        check("t1_evt_count", evt_cnt - evt0, 1);
        check("t1_evt_cycle", first_evt, 16);
        check("t1_key_code", key_code, 4'h5);
        check("t1_digits", digits, 16'h0005);
        check("t1_digit_cnt", digit_cnt, 1);
        key_in = 5'h10;
        run(20);
        press(5'h0B);
        check("t1_clear", digits, 16'h0000);

        // 2: bouncing press, then steady
        evt0 = evt_cnt;
        for (int i = 0; i < 40; i++) begin
            key_in = (((i / 3) % 2) == 0) ? 5'h07 : 5'h10;
            run(1);
        end
        check("t2_bounce_no_evt", evt_cnt - evt0, 0);
        key_in = 5'h07;
        run(30);
        check("t2_evt_cycle", first_evt, 16);
        check("t2_evt_count", evt_cnt - evt0, 1);
        check("t2_digits", digits, 16'h0007);
        key_in = 5'h10;
        run(20);
        press(5'h0B);

        // 3: overflow and commit
        evt0 = evt_cnt;
        vv0  = vv_cnt;
        press(5'h01);
        press(5'h02);
        press(5'h03);
        press(5'h04);
        press(5'h05);
        check("t3_evt_count", evt_cnt - evt0, 5);
        check("t3_digits", digits, 16'h1234);
        check("t3_digit_cnt", digit_cnt, 4);
        check("t3_full", full, 1);
        press(5'h0F);
        check("t3_vv_cycles", vv_cnt - vv0, 1);
        check("t3_value", value, 16'h1234);
        check("t3_digits_clr", digits, 0);
        check("t3_cnt_clr", digit_cnt, 0);
        check("t3_full_clr", full, 0);

        // 4: backspace, underflow, empty enter, clear
        vv0 = vv_cnt;
        press(5'h01);
        press(5'h02);
        press(5'h0A);
        check("t4_bksp_digits", digits, 16'h0001);
        check("t4_bksp_cnt", digit_cnt, 1);
        press(5'h0A);
        press(5'h0A);
        check("t4_under_digits", digits, 0);
        check("t4_under_cnt", digit_cnt, 0);
        press(5'h0F);
        check("t4_empty_enter_vv", vv_cnt - vv0, 0);
        check("t4_value_hold", value, 16'h1234);
        press(5'h09);
        check("t4_nine", digits, 16'h0009);
        press(5'h0B);
        check("t4_clear_digits", digits, 0);
        check("t4_clear_cnt", digit_cnt, 0);

        // 5: release bounce must not retrigger
        evt0   = evt_cnt;
        key_in = 5'h08;
        run(20);
        key_in = 5'h10;
        run(5);
        key_in = 5'h08;
        run(50);
        key_in = 5'h10;
        run(20);
        check("t5_evt_count", evt_cnt - evt0, 1);
        check("t5_digits", digits, 16'h0008);
        press(5'h0B);

        // 6: reset mid-debounce
        press(5'h04);
        press(5'h02);
        check("t6_pre_digits", digits, 16'h0042);
        evt0   = evt_cnt;
        key_in = 5'h03;
        run(10);
        check("t6_no_evt_yet", evt_cnt - evt0, 0);
        #1 RST_N = 1'b0;
        #1;
        check("t6_rst_digits", digits, 0);
        check("t6_rst_cnt", digit_cnt, 0);
        check("t6_rst_code", key_code, 0);
        check("t6_rst_evt", key_evt, 0);
        run(2);
        RST_N = 1'b1;
        run(30);
        check("t6_evt_cycle", first_evt, 16);
        check("t6_code", key_code, 4'h3);
        check("t6_digits", digits, 16'h0003);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
